// File: rtl/stb_burst_writer_if.sv
// Store-buffer write-master bundle: request, data FIFO, memory write bus and burst response.
// The master modport is the burst writer; the slave modport is the surrounding environment.
interface stb_burst_writer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int BYTE_STRB  = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_bytes;

  logic                  data_valid;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] data;

  logic [ADDR_WIDTH-1:0] maddr;
  logic                  mread;
  logic                  mwrite;
  logic [2:0]            msize;
  logic [1:0]            mburst;
  logic [3:0]            mlen;
  logic                  mlast;
  logic [DATA_WIDTH-1:0] mdata;
  logic [BYTE_STRB-1:0]  mwstrb;
  logic                  saccept;

  logic                  svalid;
  logic [1:0]            sresp;
  logic                  mready;

  logic                  done;
  logic                  err;

  modport master (
    input  req_valid, req_addr, req_bytes,
    input  data_valid, data,
    input  saccept, svalid, sresp,
    output req_ready, data_ready,
    output maddr, mread, mwrite, msize, mburst, mlen, mlast, mdata, mwstrb,
    output mready, done, err
  );

  modport slave (
    output req_valid, req_addr, req_bytes,
    output data_valid, data,
    output saccept, svalid, sresp,
    input  req_ready, data_ready,
    input  maddr, mread, mwrite, msize, mburst, mlen, mlast, mdata, mwstrb,
    input  mready, done, err
  );
endinterface

// File: rtl/stb_burst_writer.sv
// Splits a store request into INCR bursts of up to MAX_BURST beats, streams FIFO data onto the
// write bus (first beat the cycle after accept) and waits for each burst response before the next.
module stb_burst_writer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int BYTE_STRB  = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  stb_burst_writer_if.master  bus
);

  localparam int BEAT_SHIFT = $clog2(BYTE_STRB);
  localparam int REM_WIDTH  = LEN_WIDTH - BEAT_SHIFT + 1;
  localparam int BCNT_WIDTH = $clog2(MAX_BURST) + 1;
  localparam int MLEN_WIDTH = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BEAT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] maddr;
  logic [MLEN_WIDTH-1:0] mlen;
  logic                  mlast;
  logic [BYTE_STRB-1:0]  mwstrb;
  logic [BYTE_STRB-1:0]  tail_strb;
  logic                  err;
  logic [REM_WIDTH-1:0]  remaining;
  logic [BCNT_WIDTH-1:0] burst_cnt;

  logic                  accept;
  logic                  xfer;
  logic                  resp_take;
  logic                  load;
  logic [BEAT_SHIFT-1:0] req_frac;
  logic [REM_WIDTH-1:0]  req_beats;
  logic [BYTE_STRB-1:0]  req_tail;
  logic [REM_WIDTH-1:0]  load_rem;
  logic [BYTE_STRB-1:0]  load_tail;
  logic [BCNT_WIDTH-1:0] load_burst;

  assign accept    = (state == IDLE) & bus.req_valid;
  assign xfer      = (state == BEAT) & bus.data_valid & bus.saccept;
  assign resp_take = (state == RESP) & bus.svalid;

  assign req_frac  = bus.req_bytes[BEAT_SHIFT-1:0];
  assign req_beats = REM_WIDTH'(bus.req_bytes >> BEAT_SHIFT) + REM_WIDTH'(|req_frac);

  // A partial final beat enables only its low (bytes mod beat size) byte lanes.
  always_comb begin
    req_tail = '1;
    if (req_frac != '0) begin
      req_tail = ~({BYTE_STRB{1'b1}} << req_frac);
    end
  end

  // Burst parameters come from the request on accept, otherwise from the running remainder.
  assign load       = (accept & (bus.req_bytes != '0)) | (resp_take & (remaining != '0));
  assign load_rem   = (state == IDLE) ? req_beats : remaining;
  assign load_tail  = (state == IDLE) ? req_tail : tail_strb;
  assign load_burst = (load_rem > REM_WIDTH'(MAX_BURST)) ? BCNT_WIDTH'(MAX_BURST)
                                                         : BCNT_WIDTH'(load_rem);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      err       <= 1'b0;
      maddr     <= '0;
      remaining <= '0;
      tail_strb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            maddr     <= bus.req_addr;
            remaining <= req_beats;
            tail_strb <= req_tail;
            err       <= 1'b0;
            state     <= (bus.req_bytes == '0) ? DONE : BEAT;
          end
        end
        BEAT: begin
          if (xfer) begin
            maddr     <= maddr + ADDR_WIDTH'(1);
            remaining <= remaining - REM_WIDTH'(1);
            if (mlast) begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.svalid) begin
            if (bus.sresp != 2'b01) begin
              err <= 1'b1;
            end
            state <= (remaining != '0) ? BEAT : DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-beat qualifiers are registered so mlast and the final strobe line up with the beat shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
      mlen      <= '0;
      mlast     <= 1'b0;
      mwstrb    <= '0;
    end else if (load) begin
      burst_cnt <= load_burst;
      mlen      <= MLEN_WIDTH'(load_burst - BCNT_WIDTH'(1));
      mlast     <= (load_burst == BCNT_WIDTH'(1));
      mwstrb    <= (load_rem == REM_WIDTH'(1)) ? load_tail : '1;
    end else if (xfer) begin
      burst_cnt <= burst_cnt - BCNT_WIDTH'(1);
      mlast     <= (burst_cnt == BCNT_WIDTH'(2));
      mwstrb    <= (remaining == REM_WIDTH'(2)) ? tail_strb : '1;
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.data_ready = (state == BEAT) & bus.saccept;
  assign bus.mwrite     = (state == BEAT) & bus.data_valid;
  assign bus.mdata      = bus.data;
  assign bus.maddr      = maddr;
  assign bus.mread      = 1'b0;
  assign bus.msize      = 3'b100;
  assign bus.mburst     = 2'b01;
  assign bus.mlen       = mlen;
  assign bus.mlast      = mlast;
  assign bus.mwstrb     = mwstrb;
  assign bus.mready     = (state == RESP);
  assign bus.done       = (state == DONE);
  assign bus.err        = err;

endmodule
